// File: rtl/parity_pkg.sv
// Shared definitions for the XOR parity generator / checker pair.
// Frame format: 8 data bits LSB-first followed by one parity bit.
package parity_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 9;
  localparam int IDX_W      = $clog2(DATA_W);

  typedef enum logic {
    RX_DATA = 1'b0,
    RX_PAR  = 1'b1
  } rx_state_t;

  // Parity bit a transmitter appends to data; odd=1 selects odd parity.
  function automatic logic expected_parity(input logic [DATA_W-1:0] data,
                                           input logic              odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/par_out_buf.sv
// Single-entry valid/ready holding register. A load that arrives while the
// entry is held and not being accepted is dropped and flagged for one cycle.
module par_out_buf
  import parity_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_perr,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_perr,
  output logic         drop
);

  logic accept;
  logic can_load;

  assign accept   = out_valid && out_ready;
  // The slot is free if empty or being emptied on this same edge.
  assign can_load = !out_valid || out_ready;
  assign drop     = load && !can_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_perr  <= 1'b0;
    end else if (load && can_load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_perr  <= load_perr;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/parity_rx_checker.sv
// Bit-serial receiver for 8-bit parity-protected frames, with a one-entry
// output buffer, saturating parity-error counter and sticky overrun flag.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   RX_DATA | shifting data bit [idx] (0..7) into the byte
//   RX_PAR  | waiting for the parity bit that closes the frame
module parity_rx_checker
  import parity_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin_valid,
  input  logic              sin_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic [CNT_W-1:0]  err_count,
  output logic              overrun,
  input  logic              clr_stats
);

  rx_state_t         state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              acc, acc_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              frame_done;
  logic              frame_perr;
  logic              frame_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_DATA;
      idx   <= '0;
      acc   <= 1'b0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      acc   <= acc_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    acc_nxt    = acc;
    shreg_nxt  = shreg;
    frame_done = 1'b0;
    frame_perr = 1'b0;
    case (state)
      RX_DATA: begin
        if (sin_valid) begin
          shreg_nxt[idx] = sin_bit;
          acc_nxt        = acc ^ sin_bit;
          if (idx == IDX_W'(DATA_W - 1)) begin
            state_nxt = RX_PAR;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      RX_PAR: begin
        if (sin_valid) begin
          frame_done = 1'b1;
          frame_perr = acc ^ sin_bit ^ ODD_PARITY;
          state_nxt  = RX_DATA;
          idx_nxt    = '0;
          acc_nxt    = 1'b0;
        end
      end
      default: begin
        state_nxt = RX_DATA;
        idx_nxt   = '0;
        acc_nxt   = 1'b0;
      end
    endcase
  end

  // shreg is complete while in RX_PAR, so it can be loaded on the parity edge.
  par_out_buf #(
    .W(DATA_W)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (frame_done),
    .load_data (shreg),
    .load_perr (frame_perr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_perr  (out_perr),
    .drop      (frame_drop)
  );

  // Dropped frames still count towards the error statistic.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      err_count <= '0;
    end else if (frame_done && frame_perr && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      overrun <= 1'b0;
    end else if (frame_drop) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_rx_checker.sv
// Self-checking bench: even- and odd-parity instances share one stimulus
// stream and are compared against a frame-level reference model.
module tb_parity_rx_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin_valid = 1'b0;
  logic       sin_bit = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_stats = 1'b0;

  logic       ov_e, ov_o, perr_e, perr_o, ovr_e, ovr_o;
  logic [7:0] data_e, data_o, cnt_e, cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state (index 0 = even instance, 1 = odd instance)
  bit         bits[$];
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_perr [2];
  logic [7:0] m_err  [2];
  logic       m_ovr;

  always #5 clk = ~clk;

  parity_rx_checker #(.ODD_PARITY(1'b0), .CNT_W(8)) dut_e (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .out_valid(ov_e), .out_ready(out_ready), .out_data(data_e),
    .out_perr(perr_e), .err_count(cnt_e), .overrun(ovr_e), .clr_stats(clr_stats)
  );

  parity_rx_checker #(.ODD_PARITY(1'b1), .CNT_W(8)) dut_o (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .out_valid(ov_o), .out_ready(out_ready), .out_data(data_o),
    .out_perr(perr_o), .err_count(cnt_o), .overrun(ovr_o), .clr_stats(clr_stats)
  );

  task automatic model_step();
    bit         complete = 1'b0;
    bit         drop = 1'b0;
    logic [7:0] bv = 8'h00;
    bit         pbit = 1'b0;
    logic       pe [2];
    pe[0] = 1'b0;
    pe[1] = 1'b0;
    if (rst) begin
      bits.delete();
      m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0;
      for (int k = 0; k < 2; k++) begin m_perr[k] = 1'b0; m_err[k] = 8'h00; end
    end else begin
      if (sin_valid) begin
        bits.push_back(sin_bit);
        if (bits.size() == 9) begin
          complete = 1'b1;
          for (int i = 0; i < 8; i++) bv[i] = bits[i];
          pbit = bits[8];
          bits.delete();
        end
      end
      pe[0] = ((^bv) != pbit);
      pe[1] = !pe[0];
      if (complete && (!m_valid || out_ready)) begin
        m_valid = 1'b1; m_data = bv; m_perr[0] = pe[0]; m_perr[1] = pe[1];
      end else if (complete) begin
        drop = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        if (clr_stats) m_err[k] = 8'h00;
        else if (complete && pe[k] && m_err[k] != 8'hFF) m_err[k] = m_err[k] + 8'd1;
      end
      if (clr_stats) m_ovr = 1'b0;
      else if (drop) m_ovr = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p, input int max_gap,
                            input bit clr_last);
    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        sin_valid = 1'b0;
        tick();
      end
      sin_valid = 1'b1;
      sin_bit   = (i < 8) ? d[i] : p;
      clr_stats = clr_last && (i == 8);
      tick();
    end
    sin_valid = 1'b0;
    clr_stats = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({ov_e, data_e, perr_e, cnt_e, ovr_e} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_even: got v=%b d=%h p=%b cnt=%h ovr=%b, want all zero",
               ov_e, data_e, perr_e, cnt_e, ovr_e);
    end
    n_checks++;
    if ({ov_o, data_o, perr_o, cnt_o, ovr_o} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_odd: got v=%b d=%h p=%b cnt=%h ovr=%b, want all zero",
               ov_o, data_o, perr_o, cnt_o, ovr_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_good_frame();
    out_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 0, 1'b0);
    n_checks++;
    if ({ov_e, data_e, perr_e, cnt_e} !== {1'b1, 8'hA5, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL good_a5: got v=%b d=%h p=%b cnt=%h, want v=1 d=a5 p=0 cnt=00",
               ov_e, data_e, perr_e, cnt_e);
    end
    n_checks++;
    if ({ov_o, data_o, perr_o, cnt_o} !== {m_valid, m_data, m_perr[1], m_err[1]}) begin
      n_fail++;
      $display("FAIL good_a5_odd: got v=%b d=%h p=%b cnt=%h, want v=%b d=%h p=%b cnt=%h",
               ov_o, data_o, perr_o, cnt_o, m_valid, m_data, m_perr[1], m_err[1]);
    end
    tick();
    n_checks++;
    if (ov_e !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_a5: out_valid got %b, want 0", ov_e);
    end
  endtask

  task automatic test_bad_parity();
    send_frame(8'h01, 1'b0, 0, 1'b0);
    n_checks++;
    if ({data_e, perr_e, cnt_e} !== {8'h01, 1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL bad_01_even: got d=%h p=%b cnt=%h, want d=01 p=1 cnt=01",
               data_e, perr_e, cnt_e);
    end
    n_checks++;
    if ({data_o, perr_o, cnt_o} !== {8'h01, 1'b0, m_err[1]}) begin
      n_fail++;
      $display("FAIL bad_01_odd: got d=%h p=%b cnt=%h, want d=01 p=0 cnt=%h",
               data_o, perr_o, cnt_o, m_err[1]);
    end
    tick();
  endtask

  task automatic test_gaps();
    logic [7:0] d = 8'h3C;
    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(5, 0)) begin
        sin_valid = 1'b0;
        tick();
        n_checks++;
        if (ov_e !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_idle: out_valid got %b during gap before bit %0d, want 0", ov_e, i);
        end
      end
      sin_valid = 1'b1;
      sin_bit   = (i < 8) ? d[i] : 1'b0;
      tick();
      if (i < 8) begin
        n_checks++;
        if (ov_e !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_bit: out_valid got %b after bit %0d, want 0", ov_e, i);
        end
      end
    end
    sin_valid = 1'b0;
    n_checks++;
    if ({ov_e, data_e, perr_e} !== {1'b1, 8'h3C, 1'b0}) begin
      n_fail++;
      $display("FAIL gap_3c: got v=%b d=%h p=%b, want v=1 d=3c p=0", ov_e, data_e, perr_e);
    end
    tick();
  endtask

  task automatic test_overrun();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 0, 1'b0);
    send_frame(8'h22, 1'b1, 2, 1'b0);
    repeat (3) tick();
    n_checks++;
    if ({ov_e, data_e, perr_e, ovr_e, cnt_e} !== {1'b1, 8'h11, 1'b0, 1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL overrun_even: got v=%b d=%h p=%b ovr=%b cnt=%h, want v=1 d=11 p=0 ovr=1 cnt=01",
               ov_e, data_e, perr_e, ovr_e, cnt_e);
    end
    n_checks++;
    if ({ov_o, data_o, perr_o, ovr_o, cnt_o} !== {m_valid, m_data, m_perr[1], m_ovr, m_err[1]}) begin
      n_fail++;
      $display("FAIL overrun_odd: got v=%b d=%h p=%b ovr=%b cnt=%h, want v=%b d=%h p=%b ovr=%b cnt=%h",
               ov_o, data_o, perr_o, ovr_o, cnt_o, m_valid, m_data, m_perr[1], m_ovr, m_err[1]);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({ov_e, ovr_e} !== 2'b01) begin
      n_fail++;
      $display("FAIL overrun_accept: got v=%b ovr=%b, want v=0 ovr=1", ov_e, ovr_e);
    end
  endtask

  task automatic test_rst_midframe();
    out_ready = 1'b0;
    send_frame(8'h77, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sin_valid = 1'b1;
      sin_bit   = 1'($urandom_range(1, 0));
      tick();
    end
    sin_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({ov_e, data_e, ovr_e, cnt_e} !== 18'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%b d=%h ovr=%b cnt=%h, want all zero", ov_e, data_e, ovr_e, cnt_e);
    end
    out_ready = 1'b1;
    send_frame(8'h5A, 1'b0, 1, 1'b0);
    n_checks++;
    if ({ov_e, data_e, perr_e} !== {1'b1, 8'h5A, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_5a: got v=%b d=%h p=%b, want v=1 d=5a p=0", ov_e, data_e, perr_e);
    end
    tick();
    n_checks++;
    if (ov_e !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_spurious: out_valid got %b, want 0", ov_e);
    end
  endtask

  task automatic test_saturate();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    out_ready = 1'b1;
    repeat (255) send_frame(8'h01, 1'b0, 0, 1'b0);
    n_checks++;
    if (cnt_e !== 8'hFF) begin
      n_fail++;
      $display("FAIL sat_255: err_count got %h, want ff", cnt_e);
    end
    send_frame(8'h01, 1'b0, 0, 1'b0);
    n_checks++;
    if (cnt_e !== 8'hFF) begin
      n_fail++;
      $display("FAIL sat_hold: err_count got %h, want ff", cnt_e);
    end
    n_checks++;
    if (cnt_o !== m_err[1]) begin
      n_fail++;
      $display("FAIL sat_odd: err_count got %h, want %h", cnt_o, m_err[1]);
    end
    out_ready = 1'b0;
    send_frame(8'h01, 1'b0, 0, 1'b0);
    n_checks++;
    if ({ovr_e, cnt_e} !== {1'b1, 8'hFF}) begin
      n_fail++;
      $display("FAIL sat_drop: got ovr=%b cnt=%h, want ovr=1 cnt=ff", ovr_e, cnt_e);
    end
    send_frame(8'h01, 1'b0, 0, 1'b1);
    n_checks++;
    if ({ovr_e, cnt_e} !== 9'h0) begin
      n_fail++;
      $display("FAIL clr_priority: got ovr=%b cnt=%h, want ovr=0 cnt=00", ovr_e, cnt_e);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      sin_valid = ($urandom_range(9, 0) < 8);
      sin_bit   = 1'($urandom_range(1, 0));
      out_ready = ($urandom_range(3, 0) != 0);
      clr_stats = ($urandom_range(39, 0) == 0);
      tick();
      n_checks++;
      if ({ov_e, data_e, perr_e, cnt_e, ovr_e} !== {m_valid, m_data, m_perr[0], m_err[0], m_ovr}) begin
        n_fail++;
        $display("FAIL rand_even cyc %0d: got v=%b d=%h p=%b cnt=%h ovr=%b, want v=%b d=%h p=%b cnt=%h ovr=%b",
                 c, ov_e, data_e, perr_e, cnt_e, ovr_e, m_valid, m_data, m_perr[0], m_err[0], m_ovr);
      end
      n_checks++;
      if ({ov_o, data_o, perr_o, cnt_o, ovr_o} !== {m_valid, m_data, m_perr[1], m_err[1], m_ovr}) begin
        n_fail++;
        $display("FAIL rand_odd cyc %0d: got v=%b d=%h p=%b cnt=%h ovr=%b, want v=%b d=%h p=%b cnt=%h ovr=%b",
                 c, ov_o, data_o, perr_o, cnt_o, ovr_o, m_valid, m_data, m_perr[1], m_err[1], m_ovr);
      end
    end
    sin_valid = 1'b0;
    clr_stats = 1'b0;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_gaps();
    test_overrun();
    test_rst_midframe();
    test_saturate();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_rx_checker.md
# parity_rx_checker

Bit-serial receiver and checker for parity-protected 8-bit frames; it is the receive-side counterpart to the team's 8-bit XOR parity generator. It shifts in 8 data bits LSB-first, then one parity bit. It recomputes parity, presents the byte with an error flag on a valid/ready output, and keeps a saturating error counter and a sticky overrun flag. It sits between a serial link front-end and byte-wide consumer logic. It also serves as a gate-level CGP optimisation target.

## Interface
- `ODD_PARITY`, default 0; 0 = even parity (parity bit = XOR of data bits), 1 = odd parity (parity bit = inverted XOR).
- `CNT_W`, default 8; width of the error counter.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sin_valid`  in  1  qualifies `sin_bit` this cycle.
- `sin_bit`  in  1  serial data; 8 data bits LSB-first, then the parity bit.
- `out_valid`  out  1  byte available.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `out_data`  out  8  received byte.
- `out_perr`  out  1  parity mismatch for `out_data`.
- `err_count`  out  CNT_W  number of frames with a parity error; saturates at all-ones.
- `overrun`  out  1  sticky flag: a completed frame was dropped.
- `clr_stats`  in  1  synchronous clear of `err_count` and `overrun`.

## Operation
- States: `RX_DATA` (bit index 0..7) and `RX_PAR`. Reset state is `RX_DATA` with index 0.
- In `RX_DATA`, each `sin_valid` cycle shifts `sin_bit` into bit[index] and XORs it into a running accumulator. Index 7 moves the block to `RX_PAR`.
- In `RX_PAR`, a `sin_valid` cycle completes the frame. perr = acc ^ sin_bit ^ ODD_PARITY. The block then returns to `RX_DATA`, index 0, accumulator cleared.
- A `sin_valid`=0 cycle holds all receive state. Gaps of any length are allowed anywhere in a frame.
- Output buffer holds one entry.
  - On completion with the buffer empty, or with the buffer being accepted in the same cycle: load the buffer and set `out_valid`=1.
  - On completion with `out_valid`=1 and `out_ready`=0: drop the new frame, keep the held byte unchanged, and set `overrun`=1.
- `out_data`/`out_perr` are stable while `out_valid`=1 and `out_ready`=0.
- `err_count` increments when a completing frame has perr=1, whether the frame is loaded or dropped. It saturates and does not wrap.
- `clr_stats` zeroes `err_count` and `overrun`. It has priority over a same-cycle increment or overrun set; that event is lost.
- Receive and output paths do not depend on `clr_stats`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0x00, `out_perr`=0, `err_count`=0, `overrun`=0; receiver at `RX_DATA` index 0.
- `rst` mid-frame discards the partial frame and any buffered byte.
- Latency: the parity bit is sampled at edge N. `out_valid`, `out_data` and `out_perr` are updated at edge N, so they are visible in cycle N+1. `err_count` and `overrun` update on the same edge.
- Minimum frame time is 9 cycles. Back-to-back frames sustain full rate when `out_ready`=1.
- Handshake: the transfer happens on an edge where `out_valid && out_ready`. `out_valid` drops on the next edge unless a frame completes on that same edge.

## Structure
- Shared package `parity_pkg` holds:
  - `DATA_W`=8 and `FRAME_BITS`=9;
  - the state enum {`RX_DATA`, `RX_PAR`};
  - a function for the expected parity bit given data and `ODD_PARITY`, shared with the transmit-side generator.
- One sub-module: `par_out_buf`, the single-entry valid/ready holding register with a drop/overrun indication.
- Receive FSM, accumulator and counters live in the top level.

## Test plan
- Even parity, frame 0xA5 with parity 0, `out_ready`=1 -> `out_data`=0xA5, `out_perr`=0 one cycle after the parity bit; `err_count`=0.
- Frame 0x01 with parity 0 (bad for even) -> `out_perr`=1, `err_count`=1. Repeat with `ODD_PARITY`=1 -> `out_perr`=0.
- Frame 0x3C sent with random `sin_valid` gaps (up to 5 idle cycles) -> 0x3C, `out_perr`=0; no output during the gaps.
- `out_ready`=0, send 0x11 then 0x22 (bad parity) -> 0x11 is held, `overrun`=1, `err_count`=1. Raise `out_ready` -> 0x11 is accepted and `out_valid` falls.
- `rst` after 4 data bits, then a full 0x5A frame -> a single output 0x5A with no spurious byte.
- Force 255 errors at `CNT_W`=8, then one more -> `err_count` stays 0xFF. Then pulse `clr_stats` together with an error completion -> `err_count`=0 and `overrun`=0.
